alu_scheduler: RTL and testbench

Reservation station and issue scheduler for the single ALU. It accepts decoded ALU instructions from dispatch and holds them until both operands are available, snooping the common data bus (CDB) for producer results. Each cycle it issues at most one ready entry to the ALU. It sits between the dispatcher/ROB and the ALU, and drives the ALU's `en`, `rob_id_in`, `data_j`, `data_k`, `imm` and `type` inputs.

---
 rtl/alu_scheduler_pkg.sv | 33 +++
 rtl/prio_enc_lsb.sv | 25 ++
 rtl/alu_scheduler.sv | 166 ++++++++++++++++
 tb/tb_alu_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_scheduler_pkg.sv
// alu_scheduler_pkg: shared ALU-scheduler types.
//   RS_TYPE_WIDTH  width of the ALU operation field
//   alu_op_e       ALU operation encodings carried on disp_type / alu_type
//   rs_entry_t     operand payload held per reservation-station entry
package alu_scheduler_pkg;

    localparam int unsigned RS_TYPE_WIDTH = 5;

    typedef enum logic [RS_TYPE_WIDTH-1:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd,
        AluLui,
        AluAuipc
    } alu_op_e;

    // Payload that travels to the ALU on issue; producer tags live separately.
    typedef struct packed {
        logic [31:0]              rob_id;
        logic [31:0]              vj;
        logic [31:0]              vk;
        logic [31:0]              imm;
        logic [RS_TYPE_WIDTH-1:0] op;
    } rs_entry_t;

endpackage

// File: rtl/prio_enc_lsb.sv
// prio_enc_lsb: lowest-set-bit priority encoder.
//   req    request vector
//   valid  any request bit set
//   idx    index of the lowest set bit (0 when valid is low)
module prio_enc_lsb #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned IDX_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     req,
    output logic                 valid,
    output logic [IDX_WIDTH-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Descending scan so the lowest set bit wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: reservation station and single-issue scheduler for the ALU.
//   clk_in, rst_in (sync, active-high), rdy_in (global hold), flush
//   disp_*   dispatch request: rob id, op, operand values/tags/busy, immediate
//   cdb_*    common data bus broadcast: valid, rob id, value
//   full     every entry busy
//   alu_*    registered issue outputs: en strobe, rob id, operands, imm, op
module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int unsigned RS_SIZE = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic                     disp_valid,
    input  logic [31:0]              disp_rob_id,
    input  logic [RS_TYPE_WIDTH-1:0] disp_type,
    input  logic [31:0]              disp_vj,
    input  logic [31:0]              disp_vk,
    input  logic [31:0]              disp_qj,
    input  logic [31:0]              disp_qk,
    input  logic                     disp_qj_busy,
    input  logic                     disp_qk_busy,
    input  logic [31:0]              disp_imm,
    input  logic                     cdb_valid,
    input  logic [31:0]              cdb_rob_id,
    input  logic [31:0]              cdb_value,
    output logic                     full,
    output logic                     alu_en,
    output logic [31:0]              alu_rob_id,
    output logic [31:0]              alu_data_j,
    output logic [31:0]              alu_data_k,
    output logic [31:0]              alu_imm,
    output logic [RS_TYPE_WIDTH-1:0] alu_type
);

    localparam int unsigned IDX_WIDTH = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
    logic [RS_SIZE-1:0] qk_busy_q, qk_busy_d;
    logic [31:0]        qj_q [RS_SIZE];
    logic [31:0]        qj_d [RS_SIZE];
    logic [31:0]        qk_q [RS_SIZE];
    logic [31:0]        qk_d [RS_SIZE];
    rs_entry_t          ent_q [RS_SIZE];
    rs_entry_t          ent_d [RS_SIZE];
    logic               alu_en_q, alu_en_d;
    rs_entry_t          issue_q, issue_d;

    logic [RS_SIZE-1:0]   ready;
    logic                 free_valid, sel_valid;
    logic [IDX_WIDTH-1:0] free_idx, sel_idx;

    assign ready = busy_q & ~qj_busy_q & ~qk_busy_q;
    assign full  = &busy_q;

    prio_enc_lsb #(
        .WIDTH     (RS_SIZE),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_free_enc (
        .req   (~busy_q),
        .valid (free_valid),
        .idx   (free_idx)
    );

    prio_enc_lsb #(
        .WIDTH     (RS_SIZE),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_sel_enc (
        .req   (ready),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    always_comb begin
        busy_d    = busy_q;
        qj_busy_d = qj_busy_q;
        qk_busy_d = qk_busy_q;
        qj_d      = qj_q;
        qk_d      = qk_q;
        ent_d     = ent_q;
        alu_en_d  = alu_en_q;
        issue_d   = issue_q;

        if (rdy_in) begin
            if (flush) begin
                busy_d   = '0;
                alu_en_d = 1'b0;
            end else begin
                // Wakeup only touches waiting entries, so it never collides with
                // the selected (ready) slot or the free slot being written.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (cdb_valid && busy_q[i]) begin
                        if (qj_busy_q[i] && qj_q[i] == cdb_rob_id) begin
                            ent_d[i].vj  = cdb_value;
                            qj_busy_d[i] = 1'b0;
                        end
                        if (qk_busy_q[i] && qk_q[i] == cdb_rob_id) begin
                            ent_d[i].vk  = cdb_value;
                            qk_busy_d[i] = 1'b0;
                        end
                    end
                end

                alu_en_d = sel_valid;
                if (sel_valid) begin
                    busy_d[sel_idx] = 1'b0;
                    issue_d         = ent_q[sel_idx];
                end

                // free_valid is !full; the free slot comes from pre-edge busy.
                if (disp_valid && free_valid) begin
                    busy_d[free_idx]        = 1'b1;
                    qj_d[free_idx]          = disp_qj;
                    qk_d[free_idx]          = disp_qk;
                    qj_busy_d[free_idx]     = disp_qj_busy;
                    qk_busy_d[free_idx]     = disp_qk_busy;
                    ent_d[free_idx].rob_id  = disp_rob_id;
                    ent_d[free_idx].vj      = disp_vj;
                    ent_d[free_idx].vk      = disp_vk;
                    ent_d[free_idx].imm     = disp_imm;
                    ent_d[free_idx].op      = disp_type;
                    if (cdb_valid && disp_qj_busy && disp_qj == cdb_rob_id) begin
                        ent_d[free_idx].vj  = cdb_value;
                        qj_busy_d[free_idx] = 1'b0;
                    end
                    if (cdb_valid && disp_qk_busy && disp_qk == cdb_rob_id) begin
                        ent_d[free_idx].vk  = cdb_value;
                        qk_busy_d[free_idx] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q   <= '0;
            alu_en_q <= 1'b0;
            issue_q  <= '0;
        end else begin
            busy_q   <= busy_d;
            alu_en_q <= alu_en_d;
            issue_q  <= issue_d;
        end
    end

    // Payload and tags are qualified by busy, so they need no reset.
    always_ff @(posedge clk_in) begin
        qj_busy_q <= qj_busy_d;
        qk_busy_q <= qk_busy_d;
        qj_q      <= qj_d;
        qk_q      <= qk_d;
        ent_q     <= ent_d;
    end

    assign alu_en     = alu_en_q;
    assign alu_rob_id = issue_q.rob_id;
    assign alu_data_j = issue_q.vj;
    assign alu_data_k = issue_q.vk;
    assign alu_imm    = issue_q.imm;
    assign alu_type   = issue_q.op;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed scenarios plus randomized traffic checked against
// an entry-list model of the reservation station.
module tb_alu_scheduler;
    import alu_scheduler_pkg::*;

    localparam int NUM = 8;

    logic                     clk_in, rst_in, rdy_in, flush;
    logic                     disp_valid, disp_qj_busy, disp_qk_busy;
    logic [31:0]              disp_rob_id, disp_vj, disp_vk, disp_qj, disp_qk, disp_imm;
    logic [RS_TYPE_WIDTH-1:0] disp_type;
    logic                     cdb_valid;
    logic [31:0]              cdb_rob_id, cdb_value;
    logic                     full, alu_en;
    logic [31:0]              alu_rob_id, alu_data_j, alu_data_k, alu_imm;
    logic [RS_TYPE_WIDTH-1:0] alu_type;

    int total = 0;
    int bad   = 0;

    alu_scheduler #(
        .RS_SIZE (NUM)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_rob_id  (disp_rob_id),
        .disp_type    (disp_type),
        .disp_vj      (disp_vj),
        .disp_vk      (disp_vk),
        .disp_qj      (disp_qj),
        .disp_qk      (disp_qk),
        .disp_qj_busy (disp_qj_busy),
        .disp_qk_busy (disp_qk_busy),
        .disp_imm     (disp_imm),
        .cdb_valid    (cdb_valid),
        .cdb_rob_id   (cdb_rob_id),
        .cdb_value    (cdb_value),
        .full         (full),
        .alu_en       (alu_en),
        .alu_rob_id   (alu_rob_id),
        .alu_data_j   (alu_data_j),
        .alu_data_k   (alu_data_k),
        .alu_imm      (alu_imm),
        .alu_type     (alu_type)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference model: a list of waiting instructions and the last issue.
    typedef struct {
        logic                     busy, qjb, qkb;
        logic [31:0]              qj, qk, vj, vk, imm, rob;
        logic [RS_TYPE_WIDTH-1:0] op;
    } m_ent_t;

    m_ent_t                   m_ent [NUM];
    logic                     m_en;
    logic [31:0]              m_rob, m_j, m_k, m_imm;
    logic [RS_TYPE_WIDTH-1:0] m_op;

    function automatic logic model_full();
        logic f = 1'b1;
        for (int i = 0; i < NUM; i++) f = f & m_ent[i].busy;
        return f;
    endfunction

    task automatic model_step();
        m_ent_t nxt [NUM];
        int sel = -1;
        int fr  = -1;
        if (rst_in) begin
            for (int i = 0; i < NUM; i++) m_ent[i].busy = 1'b0;
            m_en = 1'b0; m_rob = 0; m_j = 0; m_k = 0; m_imm = 0; m_op = '0;
            return;
        end
        if (!rdy_in) return;
        if (flush) begin
            for (int i = 0; i < NUM; i++) m_ent[i].busy = 1'b0;
            m_en = 1'b0;
            return;
        end
        nxt = m_ent;
        for (int i = 0; i < NUM; i++) begin
            if (sel < 0 && m_ent[i].busy && !m_ent[i].qjb && !m_ent[i].qkb) sel = i;
            if (fr < 0 && !m_ent[i].busy) fr = i;
            if (cdb_valid && m_ent[i].busy) begin
                if (m_ent[i].qjb && m_ent[i].qj == cdb_rob_id) begin
                    nxt[i].qjb = 1'b0; nxt[i].vj = cdb_value;
                end
                if (m_ent[i].qkb && m_ent[i].qk == cdb_rob_id) begin
                    nxt[i].qkb = 1'b0; nxt[i].vk = cdb_value;
                end
            end
        end
        m_en = (sel >= 0);
        if (sel >= 0) begin
            nxt[sel].busy = 1'b0;
            m_rob = m_ent[sel].rob; m_j = m_ent[sel].vj; m_k = m_ent[sel].vk;
            m_imm = m_ent[sel].imm; m_op = m_ent[sel].op;
        end
        if (disp_valid && fr >= 0) begin
            nxt[fr].busy = 1'b1;
            nxt[fr].rob = disp_rob_id; nxt[fr].imm = disp_imm; nxt[fr].op = disp_type;
            nxt[fr].qj = disp_qj; nxt[fr].qk = disp_qk;
            nxt[fr].qjb = disp_qj_busy; nxt[fr].qkb = disp_qk_busy;
            nxt[fr].vj = disp_vj; nxt[fr].vk = disp_vk;
            if (cdb_valid && disp_qj_busy && disp_qj == cdb_rob_id) begin
                nxt[fr].qjb = 1'b0; nxt[fr].vj = cdb_value;
            end
            if (cdb_valid && disp_qk_busy && disp_qk == cdb_rob_id) begin
                nxt[fr].qkb = 1'b0; nxt[fr].vk = cdb_value;
            end
        end
        m_ent = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0; rdy_in = 1'b1;
    endtask

    task automatic disp(input logic [31:0] rob, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] qj, input logic qjb,
                        input logic [31:0] qk, input logic qkb);
        disp_valid = 1'b1; disp_rob_id = rob; disp_vj = vj; disp_vk = vk;
        disp_qj = qj; disp_qj_busy = qjb; disp_qk = qk; disp_qk_busy = qkb;
        disp_imm = rob + 32'h100; disp_type = AluAdd;
    endtask

    task automatic cdb(input logic [31:0] rob, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_rob_id = rob; cdb_value = val;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; idle();
        disp(0, 0, 0, 0, 0, 0, 0); disp_valid = 1'b0;
        cdb_rob_id = 0; cdb_value = 0;
        tick(); tick();
        rst_in = 1'b0;
        total++;
        if (alu_en !== 1'b0 || full !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: got en=%b full=%b, want 0 0", alu_en, full);
        end
        total++;
        if ({alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type} !== '0) begin
            bad++; $display("FAIL reset_data: got rob=%0h j=%0h k=%0h imm=%0h, want 0",
                            alu_rob_id, alu_data_j, alu_data_k, alu_imm);
        end
    endtask

    task automatic test_single();
        disp(3, 5, 7, 0, 0, 0, 0);
        tick(); idle();
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL single_early: en=%b want 0", alu_en); end
        tick();
        total++;
        if (alu_en !== 1'b1 || alu_rob_id !== 32'd3 || alu_data_j !== 32'd5 ||
            alu_data_k !== 32'd7 || alu_imm !== 32'h103) begin
            bad++; $display("FAIL single_issue: en=%b rob=%0d j=%0d k=%0d imm=%0h want 1 3 5 7 103",
                            alu_en, alu_rob_id, alu_data_j, alu_data_k, alu_imm);
        end
        tick();
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL single_after: en=%b want 0", alu_en); end
    endtask

    task automatic test_wakeup();
        disp(4, 0, 1, 2, 1, 0, 0);
        tick(); idle();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) cdb(2, 32'h55);
            else tick();
            total++;
            if (alu_en !== 1'b0) begin bad++; $display("FAIL wake_early%0d: en=%b want 0", c, alu_en); end
        end
        tick(); idle();
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL wake_m1: en=%b want 0", alu_en); end
        tick();
        total++;
        if (alu_en !== 1'b1 || alu_data_j !== 32'h55 || alu_rob_id !== 32'd4) begin
            bad++; $display("FAIL wake_issue: en=%b j=%0h rob=%0d want 1 55 4", alu_en, alu_data_j, alu_rob_id);
        end
        tick();
    endtask

    task automatic test_bypass();
        disp(5, 3, 0, 0, 0, 9, 1);
        cdb(9, 32'hAA);
        tick(); idle();
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL bypass_early: en=%b want 0", alu_en); end
        tick();
        total++;
        if (alu_en !== 1'b1 || alu_data_k !== 32'hAA || alu_rob_id !== 32'd5) begin
            bad++; $display("FAIL bypass_issue: en=%b k=%0h rob=%0d want 1 aa 5", alu_en, alu_data_k, alu_rob_id);
        end
        tick();
    endtask

    task automatic test_full_order();
        for (int i = 0; i < NUM; i++) begin
            disp(20 + i, i, 0, 1, 1, 0, 0);
            tick();
        end
        total++;
        if (full !== 1'b1) begin bad++; $display("FAIL full_set: full=%b want 1", full); end
        disp(99, 1, 1, 0, 0, 0, 0);
        tick(); idle();
        total++;
        if (full !== 1'b1 || alu_en !== 1'b0) begin
            bad++; $display("FAIL full_ignore: full=%b en=%b want 1 0", full, alu_en);
        end
        cdb(1, 32'h77);
        tick(); idle();
        total++;
        if (full !== 1'b1 || alu_en !== 1'b0) begin
            bad++; $display("FAIL full_wake: full=%b en=%b want 1 0", full, alu_en);
        end
        tick();
        total++;
        if (full !== 1'b0) begin bad++; $display("FAIL full_drop: full=%b want 0", full); end
        for (int i = 0; i < NUM; i++) begin
            if (i > 0) tick();
            total++;
            if (alu_en !== 1'b1 || alu_rob_id !== 32'(20 + i) || alu_data_j !== 32'h77) begin
                bad++; $display("FAIL order%0d: en=%b rob=%0d j=%0h want 1 %0d 77",
                                i, alu_en, alu_rob_id, alu_data_j, 20 + i);
            end
        end
        tick();
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL order_end: en=%b want 0", alu_en); end
    endtask

    task automatic test_flush();
        disp(31, 0, 0, 12, 1, 0, 0); tick();
        disp(32, 0, 0, 12, 1, 0, 0); tick();
        disp(30, 1, 2, 0, 0, 0, 0);  tick();
        flush = 1'b1;
        disp(33, 1, 2, 0, 0, 0, 0);
        cdb(12, 32'h1);
        tick(); idle();
        total++;
        if (alu_en !== 1'b0 || full !== 1'b0) begin
            bad++; $display("FAIL flush_next: en=%b full=%b want 0 0", alu_en, full);
        end
        cdb(12, 32'h2);
        for (int c = 0; c < 5; c++) begin
            tick(); idle();
            total++;
            if (alu_en !== 1'b0) begin
                bad++; $display("FAIL flush_after%0d: en=%b rob=%0d want 0", c, alu_en, alu_rob_id);
            end
        end
    endtask

    task automatic test_rdy_stall();
        disp(40, 0, 0, 6, 1, 0, 0); tick();
        disp(39, 9, 9, 0, 0, 0, 0); tick();
        disp(41, 32'h41, 0, 0, 0, 0, 0); tick(); idle();
        total++;
        if (alu_en !== 1'b1 || alu_rob_id !== 32'd39) begin
            bad++; $display("FAIL stall_pre: en=%b rob=%0d want 1 39", alu_en, alu_rob_id);
        end
        rdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) cdb(6, 32'h99);
            else cdb_valid = 1'b0;
            tick();
            total++;
            if (alu_en !== 1'b1 || alu_rob_id !== 32'd39 || alu_data_j !== 32'd9) begin
                bad++; $display("FAIL stall_frozen%0d: en=%b rob=%0d j=%0h want 1 39 9",
                                c, alu_en, alu_rob_id, alu_data_j);
            end
        end
        idle();
        tick();
        total++;
        if (alu_en !== 1'b1 || alu_rob_id !== 32'd41 || alu_data_j !== 32'h41) begin
            bad++; $display("FAIL stall_resume: en=%b rob=%0d want 1 41", alu_en, alu_rob_id);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (alu_en !== 1'b0) begin
                bad++; $display("FAIL stall_lost%0d: en=%b rob=%0d want 0", c, alu_en, alu_rob_id);
            end
        end
        flush = 1'b1; tick(); idle();
        total++;
        if (full !== 1'b0 || alu_en !== 1'b0) begin
            bad++; $display("FAIL stall_clean: full=%b en=%b want 0 0", full, alu_en);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst_in       = ($urandom_range(0, 99) == 0);
            rdy_in       = ($urandom_range(0, 9) != 0);
            flush        = ($urandom_range(0, 49) == 0);
            disp_valid   = ($urandom_range(0, 1) == 1);
            disp_rob_id  = $urandom_range(0, 31);
            disp_type    = RS_TYPE_WIDTH'($urandom_range(0, 11));
            disp_vj      = $urandom;
            disp_vk      = $urandom;
            disp_qj      = $urandom_range(0, 7);
            disp_qk      = $urandom_range(0, 7);
            disp_qj_busy = ($urandom_range(0, 2) == 0);
            disp_qk_busy = ($urandom_range(0, 2) == 0);
            disp_imm     = $urandom;
            cdb_valid    = ($urandom_range(0, 4) < 2);
            cdb_rob_id   = $urandom_range(0, 7);
            cdb_value    = $urandom;
            tick();
            total++;
            if (alu_en !== m_en || full !== model_full()) begin
                bad++; $display("FAIL rand_ctrl@%0d: en=%b full=%b want %b %b",
                                c, alu_en, full, m_en, model_full());
            end
            total++;
            if ({alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type} !==
                {m_rob, m_j, m_k, m_imm, m_op}) begin
                bad++; $display("FAIL rand_data@%0d: rob=%0h j=%0h k=%0h imm=%0h op=%0d want %0h %0h %0h %0h %0d",
                                c, alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type,
                                m_rob, m_j, m_k, m_imm, m_op);
            end
        end
        rst_in = 1'b0; idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wakeup();
        test_bypass();
        test_full_order();
        test_flush();
        test_rdy_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
